// File: rtl/PARAMS_pkg.sv
// Shared core parameters and types for the memory-access stage.
// Provides data/address widths, opcode and funct3 encodings, the stage FSM
// state type, and a helper that decodes funct3 into an access size.
package PARAMS_pkg;

    localparam int unsigned WD_SIZE     = 32;
    localparam int unsigned RD_BITS     = 5;
    localparam int unsigned OPCODE_BITS = 7;
    localparam int unsigned FUNCT3_BITS = 3;
    localparam int unsigned BE_BITS     = WD_SIZE / 8;

    localparam logic [OPCODE_BITS-1:0] OPCODE_LD = 7'b0000011;
    localparam logic [OPCODE_BITS-1:0] OPCODE_ST = 7'b0100011;

    localparam logic [FUNCT3_BITS-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_BITS-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_BITS-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_BITS-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_BITS-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } acc_size_t;

    // Unsigned byte/half encodings only exist for loads; any unknown funct3 is a word.
    function automatic acc_size_t decode_size(input logic [FUNCT3_BITS-1:0] f3,
                                              input logic                   is_store);
        acc_size_t sz;
        sz = SzWord;
        if (f3 == F3_B || (!is_store && f3 == F3_BU)) begin
            sz = SzByte;
        end else if (f3 == F3_H || (!is_store && f3 == F3_HU)) begin
            sz = SzHalf;
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects the addressed byte/half of a memory word and
// sign- or zero-extends it according to funct3.
// Ports: rdata  - raw memory word
//        lane   - byte offset within the word (addr[1:0])
//        funct3 - access size / signedness
//        data   - extended result
module load_align
    import PARAMS_pkg::*;
(
    input  logic [WD_SIZE-1:0]     rdata,
    input  logic [1:0]             lane,
    input  logic [FUNCT3_BITS-1:0] funct3,
    output logic [WD_SIZE-1:0]     data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(WD_SIZE-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(WD_SIZE-8){1'b0}}, byte_sel};
            F3_H:    data = {{(WD_SIZE-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(WD_SIZE-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage following EX. Non-memory ops retire the next cycle;
// loads/stores run a req/gnt/rvalid handshake and stall EX via in_ready.
// Ports: clk/reset          - clock, async active-high reset
//        in_valid/in_ready  - EX handshake
//        opcode..rd_we      - instruction fields from EX
//        dmem_*             - data memory request/response
//        wb_*               - retire pulse and register write to writeback
//        exc_misaligned     - misaligned access pulse, coincident with wb_valid
module mem_stage
    import PARAMS_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic [FUNCT3_BITS-1:0] funct3,
    input  logic [WD_SIZE-1:0]     alu_result,
    input  logic [WD_SIZE-1:0]     store_data,
    input  logic [RD_BITS-1:0]     rd_addr,
    input  logic                   rd_we,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [WD_SIZE-1:0]     dmem_addr,
    output logic [BE_BITS-1:0]     dmem_be,
    output logic [WD_SIZE-1:0]     dmem_wdata,
    input  logic                   dmem_gnt,
    input  logic                   dmem_rvalid,
    input  logic [WD_SIZE-1:0]     dmem_rdata,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [RD_BITS-1:0]     wb_rd,
    output logic [WD_SIZE-1:0]     wb_data,
    output logic                   exc_misaligned
);

    mem_state_t               state_q, state_d;
    logic                     dmem_req_q, dmem_req_d;
    logic                     dmem_we_q, dmem_we_d;
    logic [WD_SIZE-1:0]       dmem_addr_q, dmem_addr_d;
    logic [BE_BITS-1:0]       dmem_be_q, dmem_be_d;
    logic [WD_SIZE-1:0]       dmem_wdata_q, dmem_wdata_d;
    logic                     wb_valid_q, wb_valid_d;
    logic                     wb_we_q, wb_we_d;
    logic [RD_BITS-1:0]       wb_rd_q, wb_rd_d;
    logic [WD_SIZE-1:0]       wb_data_q, wb_data_d;
    logic                     exc_q, exc_d;
    // Load context kept until rvalid
    logic [FUNCT3_BITS-1:0]   f3_q, f3_d;
    logic [1:0]               lane_q, lane_d;
    logic                     ld_we_q, ld_we_d;

    logic                     is_ld, is_st, misaligned, rd_write;
    acc_size_t                size;
    logic [WD_SIZE-1:0]       ld_data;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .lane   (lane_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    assign is_ld    = (opcode == OPCODE_LD);
    assign is_st    = (opcode == OPCODE_ST);
    assign size     = decode_size(funct3, is_st);
    assign rd_write = rd_we && (rd_addr != '0);
    assign in_ready = (state_q == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SzHalf:  misaligned = alu_result[0];
            SzWord:  misaligned = (alu_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        exc_d        = 1'b0;
        f3_d         = f3_q;
        lane_d       = lane_q;
        ld_we_d      = ld_we_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wb_rd_d = rd_addr;
                    if (is_ld || is_st) begin
                        if (misaligned) begin
                            wb_valid_d = 1'b1;
                            wb_we_d    = 1'b0;
                            exc_d      = 1'b1;
                        end else begin
                            state_d     = REQ;
                            dmem_req_d  = 1'b1;
                            dmem_we_d   = is_st;
                            dmem_addr_d = {alu_result[WD_SIZE-1:2], 2'b00};
                            f3_d        = funct3;
                            lane_d      = alu_result[1:0];
                            ld_we_d     = rd_write;
                            // Loads always fetch the whole word; extraction happens on return.
                            if (is_st && size == SzByte) begin
                                dmem_be_d    = BE_BITS'(4'b0001) << alu_result[1:0];
                                dmem_wdata_d = {4{store_data[7:0]}};
                            end else if (is_st && size == SzHalf) begin
                                dmem_be_d    = BE_BITS'(4'b0011) << alu_result[1:0];
                                dmem_wdata_d = {2{store_data[15:0]}};
                            end else begin
                                dmem_be_d    = '1;
                                dmem_wdata_d = store_data;
                            end
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = rd_write;
                        wb_data_d  = alu_result;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (dmem_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = ld_we_q;
                    wb_data_d  = ld_data;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            exc_q        <= 1'b0;
            f3_q         <= '0;
            lane_q       <= '0;
            ld_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            exc_q        <= exc_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            ld_we_q      <= ld_we_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_we          = wb_we_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign exc_misaligned = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected retires are queued when an
// instruction is driven and compared when wb_valid is seen.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    typedef struct packed {
        logic [31:0] data;
        logic        chk_data;
        logic        we;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .funct3         (funct3),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .rd_addr        (rd_addr),
        .rd_we          (rd_we),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Retire monitor
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", {31'b0, wb_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_data) check_eq("wb_data", wb_data, mon_e.data);
                check_eq("wb_we", {31'b0, wb_we}, {31'b0, mon_e.we});
                check_eq("wb_rd", {27'b0, wb_rd}, {27'b0, mon_e.rd});
                check_eq("wb_exc", {31'b0, exc_misaligned}, {31'b0, mon_e.exc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic we);
        in_valid   = 1'b1;
        opcode     = op;
        funct3     = f3;
        alu_result = alu;
        store_data = sd;
        rd_addr    = rd;
        rd_we      = we;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] exp_data, input int gnt_dly);
        sb_q.push_back(exp_t'{data: exp_data, chk_data: 1'b1, we: (rd != 0), rd: rd, exc: 1'b0});
        drive(OP_LD, f3, addr, 32'h0, rd, 1'b1);
        check_eq("ld_accept_rdy", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("ld_req", {31'b0, dmem_req}, 32'd1);
        check_eq("ld_addr", dmem_addr, {addr[31:2], 2'b00});
        check_eq("ld_be", {28'b0, dmem_be}, 32'hF);
        check_eq("ld_we", {31'b0, dmem_we}, 32'd0);
        check_eq("ld_rdy_req", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            check_eq("ld_req_hold", {31'b0, dmem_req}, 32'd1);
            check_eq("ld_addr_hold", dmem_addr, {addr[31:2], 2'b00});
            check_eq("ld_rdy_hold", {31'b0, in_ready}, 32'd0);
        end
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq("ld_wait_req", {31'b0, dmem_req}, 32'd0);
        check_eq("ld_rdy_wait", {31'b0, in_ready}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        check_eq("ld_retire", {31'b0, wb_valid}, 32'd1);
        check_eq("ld_rdy_done", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [4:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        sb_q.push_back(exp_t'{data: 32'h0, chk_data: 1'b0, we: 1'b0, rd: rd, exc: 1'b0});
        drive(OP_ST, f3, addr, sd, rd, 1'b1);
        step();
        in_valid = 1'b0;
        check_eq("st_req", {31'b0, dmem_req}, 32'd1);
        check_eq("st_we", {31'b0, dmem_we}, 32'd1);
        check_eq("st_addr", dmem_addr, {addr[31:2], 2'b00});
        check_eq("st_be", {28'b0, dmem_be}, {28'b0, exp_be});
        check_eq("st_wdata", dmem_wdata, exp_wdata);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq("st_retire", {31'b0, wb_valid}, 32'd1);
        check_eq("st_wb_we", {31'b0, wb_we}, 32'd0);
        check_eq("st_rdy", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        opcode      = '0;
        funct3      = '0;
        alu_result  = '0;
        store_data  = '0;
        rd_addr     = '0;
        rd_we       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'b0, dmem_req}, 32'd0);
        check_eq("rst_wbv", {31'b0, wb_valid}, 32'd0);
        check_eq("rst_rdy", {31'b0, in_ready}, 32'd1);
        check_eq("rst_addr", dmem_addr, 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back ALU ops retire every cycle
        for (int i = 0; i < 3; i++) begin
            drive(OP_ALU, 3'b000, 32'h0000_0005, 32'h0, 5'd3, 1'b1);
            check_eq("add_rdy", {31'b0, in_ready}, 32'd1);
            sb_q.push_back(exp_t'{data: 32'h5, chk_data: 1'b1, we: 1'b1, rd: 5'd3, exc: 1'b0});
            step();
            check_eq("add_wbv", {31'b0, wb_valid}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("add_pulse_end", {31'b0, wb_valid}, 32'd0);

        do_load(3'b000, 32'h0000_0103, 32'h80FF_1234, 5'd5, 32'hFFFF_FF80, 2);      // LB
        do_store(3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd7, 4'b1100, 32'hBEEF_BEEF); // SH

        // Misaligned LW: no request, exception pulse
        sb_q.push_back(exp_t'{data: 32'h0, chk_data: 1'b0, we: 1'b0, rd: 5'd8, exc: 1'b1});
        drive(OP_LD, 3'b010, 32'h0000_0301, 32'h0, 5'd8, 1'b1);
        step();
        in_valid = 1'b0;
        check_eq("mis_req", {31'b0, dmem_req}, 32'd0);
        check_eq("mis_wbv", {31'b0, wb_valid}, 32'd1);
        check_eq("mis_exc", {31'b0, exc_misaligned}, 32'd1);
        check_eq("mis_rdy", {31'b0, in_ready}, 32'd1);
        step();
        check_eq("mis_pulse_end", {31'b0, exc_misaligned}, 32'd0);

        do_load(3'b001, 32'h0000_0502, 32'h8001_7FFF, 5'd10, 32'hFFFF_8001, 0);     // LH
        do_load(3'b100, 32'h0000_0601, 32'h1234_A5C3, 5'd11, 32'h0000_00A5, 1);     // LBU
        do_load(3'b010, 32'h0000_0700, 32'hCAFE_F00D, 5'd12, 32'hCAFE_F00D, 0);     // LW
        do_load(3'b000, 32'h0000_0900, 32'h0000_00FF, 5'd0, 32'hFFFF_FFFF, 0);      // LB rd=0
        do_store(3'b000, 32'h0000_0801, 32'h1234_5678, 5'd13, 4'b0010, 32'h7878_7878); // SB
        do_store(3'b010, 32'h0000_0A00, 32'h0BAD_CAFE, 5'd14, 4'b1111, 32'h0BAD_CAFE); // SW

        // ALU op to x0 must not write
        sb_q.push_back(exp_t'{data: 32'h0000_0042, chk_data: 1'b1, we: 1'b0, rd: 5'd0, exc: 1'b0});
        drive(OP_ALU, 3'b000, 32'h0000_0042, 32'h0, 5'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check_eq("rd0_wbv", {31'b0, wb_valid}, 32'd1);
        check_eq("rd0_we", {31'b0, wb_we}, 32'd0);
        step();

        // LHU abandoned by reset while in WAIT, then a stray rvalid
        drive(OP_LD, 3'b101, 32'h0000_0402, 32'h0, 5'd9, 1'b1);
        step();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_eq("rst_wait_rdy", {31'b0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_req", {31'b0, dmem_req}, 32'd0);
        check_eq("arst_wbv", {31'b0, wb_valid}, 32'd0);
        check_eq("arst_rdy", {31'b0, in_ready}, 32'd1);
        check_eq("arst_addr", dmem_addr, 32'd0);
        check_eq("arst_be", {28'b0, dmem_be}, 32'd0);
        check_eq("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check_eq("arst_wb_data", wb_data, 32'd0);
        step();
        reset = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_0000;
        step();
        dmem_rvalid = 1'b0;
        check_eq("stray_wbv", {31'b0, wb_valid}, 32'd0);
        check_eq("stray_rdy", {31'b0, in_ready}, 32'd1);

        // Recovery after reset
        sb_q.push_back(exp_t'{data: 32'h0000_1234, chk_data: 1'b1, we: 1'b1, rd: 5'd4, exc: 1'b0});
        drive(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd4, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (3) step();

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
